// File: rtl/ads1256_pkg.sv
// rtl/ads1256_pkg.sv - routine encodings and ADS1256 opcodes shared by the system controller
package ads1256_pkg;

  typedef enum logic [2:0] {
    ROUTINE_NONE       = 3'd0,
    ROUTINE_CALIBRATE  = 3'd1,
    ROUTINE_READBACK   = 3'd2,
    ROUTINE_SINGLE     = 3'd3,
    ROUTINE_CONTINUOUS = 3'd4,
    ROUTINE_ILLEGAL    = 3'd7
  } routine_t;

  localparam logic [7:0] OP_WAKEUP  = 8'h00;
  localparam logic [7:0] OP_RDATA   = 8'h01;
  localparam logic [7:0] OP_RDATAC  = 8'h03;
  localparam logic [7:0] OP_SDATAC  = 8'h0F;
  localparam logic [7:0] OP_RREG    = 8'h10;
  localparam logic [7:0] OP_SELFCAL = 8'hF0;
  localparam logic [7:0] OP_SYNC    = 8'hFC;

  // RREG reads STATUS..DRATE: start address 0, count-minus-one 3
  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] RREG_COUNT  = 8'h03;

  function automatic logic [23:0] single_byte_cmd(input logic [7:0] op);
    return {op, 16'h0000};
  endfunction

endpackage

// File: rtl/ads1256_system_fsm.sv
// rtl/ads1256_system_fsm.sv - routine sequencing state machine with Mealy transaction launch
module ads1256_system_fsm
  import ads1256_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  routine_t    routine_i,
  input  logic        transaction_done_i,
  input  logic        stop_i,
  output logic        transaction_start_o,
  output logic [23:0] launch_command_o,
  output logic        idle_o,
  output logic        done_o
);

  localparam logic [3:0] IDLE              = 4'd0;
  localparam logic [3:0] CAL_SDATAC        = 4'd1;
  localparam logic [3:0] CAL_SELFCAL       = 4'd2;
  localparam logic [3:0] RB_RREG           = 4'd3;
  localparam logic [3:0] SGL_SYNC          = 4'd4;
  localparam logic [3:0] SGL_WAKEUP        = 4'd5;
  localparam logic [3:0] SGL_RDATA         = 4'd6;
  localparam logic [3:0] CONT_RDATAC_CMD   = 4'd7;
  localparam logic [3:0] CONTINUOUS_RDATAC = 4'd8;
  localparam logic [3:0] CONT_READ         = 4'd9;
  localparam logic [3:0] CONT_SDATAC       = 4'd10;
  localparam logic [3:0] DONE              = 4'd11;

  logic [3:0]  state_q, state_d;
  logic        done_q;
  logic        launch;
  logic [23:0] launch_cmd;

  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    launch_cmd = 24'h000000;
    case (state_q)
      IDLE: if (start_i) begin
        launch = 1'b1;
        case (routine_i)
          ROUTINE_CALIBRATE: begin
            state_d = CAL_SDATAC;  launch_cmd = single_byte_cmd(OP_SDATAC);
          end
          ROUTINE_READBACK: begin
            state_d = RB_RREG;     launch_cmd = {OP_RREG | REG_STATUS, RREG_COUNT, 8'h00};
          end
          ROUTINE_SINGLE: begin
            state_d = SGL_SYNC;    launch_cmd = single_byte_cmd(OP_SYNC);
          end
          ROUTINE_CONTINUOUS: begin
            state_d = CONT_RDATAC_CMD; launch_cmd = single_byte_cmd(OP_RDATAC);
          end
          default: begin
            state_d = DONE;        launch = 1'b0;
          end
        endcase
      end
      CAL_SDATAC: if (transaction_done_i) begin
        state_d = CAL_SELFCAL; launch = 1'b1; launch_cmd = single_byte_cmd(OP_SELFCAL);
      end
      CAL_SELFCAL, RB_RREG, SGL_RDATA, CONT_SDATAC:
        if (transaction_done_i) state_d = DONE;
      SGL_SYNC: if (transaction_done_i) begin
        state_d = SGL_WAKEUP; launch = 1'b1; launch_cmd = single_byte_cmd(OP_WAKEUP);
      end
      SGL_WAKEUP: if (transaction_done_i) begin
        state_d = SGL_RDATA; launch = 1'b1; launch_cmd = single_byte_cmd(OP_RDATA);
      end
      CONT_RDATAC_CMD, CONT_READ:
        if (transaction_done_i) state_d = CONTINUOUS_RDATAC;
      // Transient state: always launches exactly one transaction, either a read or the exit
      CONTINUOUS_RDATAC: begin
        launch = 1'b1;
        if (stop_i) begin
          state_d = CONT_SDATAC; launch_cmd = single_byte_cmd(OP_SDATAC);
        end else begin
          state_d = CONT_READ;   launch_cmd = single_byte_cmd(OP_WAKEUP);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign transaction_start_o = launch & ~reset_i;
  assign launch_command_o    = launch_cmd;
  assign idle_o              = (state_q == IDLE);
  assign done_o              = done_q;

endmodule

// File: rtl/ads1256_system_controller.sv
// rtl/ads1256_system_controller.sv - ADS1256 routine sequencer top: stop latch and command hold
module ads1256_system_controller
  import ads1256_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  routine_t    routine_i,
  input  logic        transaction_done_i,
  input  logic        continuous_stop_i,
  output logic        transaction_start_o,
  output logic [23:0] command_o,
  output logic        done_o
);

  logic        stop_q, stop_d;
  logic [23:0] last_cmd_q, last_cmd_d;
  logic [23:0] launch_cmd;
  logic        launch;
  logic        idle;

  ads1256_system_fsm FSM (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .routine_i           (routine_i),
    .transaction_done_i  (transaction_done_i),
    .stop_i              (stop_q),
    .transaction_start_o (launch),
    .launch_command_o    (launch_cmd),
    .idle_o              (idle),
    .done_o              (done_o)
  );

  always_comb begin
    stop_d = stop_q;
    if (idle)                   stop_d = 1'b0;
    else if (continuous_stop_i) stop_d = 1'b1;
    last_cmd_d = launch ? launch_cmd : last_cmd_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stop_q     <= 1'b0;
      last_cmd_q <= 24'h000000;
    end else begin
      stop_q     <= stop_d;
      last_cmd_q <= last_cmd_d;
    end
  end

  assign transaction_start_o = launch;
  assign command_o           = launch ? launch_cmd : last_cmd_q;

endmodule

// File: tb/tb_ads1256_system_controller.sv
// tb/tb_ads1256_system_controller.sv - scoreboard bench for the ADS1256 routine sequencer
module tb_ads1256_system_controller;
  import ads1256_pkg::*;

  logic        clk;
  logic        reset_i;
  logic        start_i;
  routine_t    routine_i;
  logic        transaction_done_i;
  logic        continuous_stop_i;
  logic        transaction_start_o;
  logic [23:0] command_o;
  logic        done_o;

  ads1256_system_controller dut (
    .clock_i             (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .routine_i           (routine_i),
    .transaction_done_i  (transaction_done_i),
    .continuous_stop_i   (continuous_stop_i),
    .transaction_start_o (transaction_start_o),
    .command_o           (command_o),
    .done_o              (done_o)
  );

  typedef struct {
    int          kind;       // 0 = transaction start, 1 = routine done
    logic [23:0] cmd;
    bit          after_txn;  // done must follow a transaction_done_i (else follows start_i)
  } exp_t;

  exp_t exp_q[$];
  int   cmp_count  = 0;
  int   fail_count = 0;
  int   starts_seen = 0;
  int   resp_lat = 2;
  int   resp_cnt = 0;
  logic prev_done_i = 1'b0;
  logic prev_start_i = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_start(input logic [23:0] cmd);
    exp_t e;
    e.kind = 0; e.cmd = cmd; e.after_txn = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit after_txn);
    exp_t e;
    e.kind = 1; e.cmd = 24'h0; e.after_txn = after_txn;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input routine_t r);
    @(posedge clk); #1;
    start_i = 1'b1; routine_i = r;
    @(posedge clk); #1;
    start_i = 1'b0; routine_i = ROUTINE_NONE;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      cmp_count++; fail_count++;
      $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (starts_seen >= target) seen = 1'b1;
    end
    if (!seen) begin
      cmp_count++; fail_count++;
      $display("FAIL %s_timeout: starts_seen=%0d, needed %0d", name, starts_seen, target);
    end
  endtask

  // SPI transaction layer model: answers each launch after resp_lat cycles
  initial begin
    transaction_done_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      transaction_done_i = (resp_cnt == 1);
      @(negedge clk);
      if (transaction_start_o) resp_cnt = resp_lat;
      else if (resp_cnt > 0)   resp_cnt--;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a start or done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (transaction_start_o) begin
        starts_seen++;
        if (exp_q.size() == 0) begin
          cmp_count++; fail_count++;
          $display("FAIL unexpected_start: command_o=%h, nothing expected", command_o);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_start", 0, e.kind);
          if (e.kind == 0) check("start_command", command_o, e.cmd);
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          cmp_count++; fail_count++;
          $display("FAIL unexpected_done: done_o=1, nothing expected");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_done", 1, e.kind);
          if (e.after_txn) check("done_after_txn_done", prev_done_i, 1);
          else             check("done_after_start", prev_start_i, 1);
        end
      end
      prev_done_i  = transaction_done_i;
      prev_start_i = start_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; routine_i = ROUTINE_NONE; continuous_stop_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("reset_start", transaction_start_o, 0);
    check("reset_done", done_o, 0);
    check("reset_command", command_o, 24'h000000);

    push_start(24'h0F0000); push_start(24'hF00000); push_done(1);
    do_start(ROUTINE_CALIBRATE);
    wait_done("calibrate", 50);
    @(negedge clk);
    check("cal_hold", command_o, 24'hF00000);

    push_start(24'h100300); push_done(1);
    do_start(ROUTINE_READBACK);
    wait_done("readback", 50);
    @(negedge clk);
    check("rb_hold", command_o, 24'h100300);

    // A start_i while SGL_SYNC is active must be ignored
    push_start(24'hFC0000); push_start(24'h000000); push_start(24'h010000); push_done(1);
    do_start(ROUTINE_SINGLE);
    start_i = 1'b1; routine_i = ROUTINE_CALIBRATE;
    @(posedge clk); #1;
    start_i = 1'b0; routine_i = ROUTINE_NONE;
    wait_done("single", 50);
    @(negedge clk);
    check("sgl_hold", command_o, 24'h010000);

    push_done(0);
    do_start(ROUTINE_ILLEGAL);
    wait_done("illegal", 5);
    @(negedge clk);
    check("illegal_hold", command_o, 24'h010000);

    push_done(0);
    do_start(ROUTINE_NONE);
    wait_done("none", 5);

    push_done(0);
    do_start(routine_t'(3'd5));
    wait_done("undefined", 5);
    @(negedge clk);
    check("undef_hold", command_o, 24'h010000);

    resp_lat = 3;
    push_start(24'h030000); push_start(24'h000000); push_start(24'h000000);
    push_start(24'h0F0000); push_done(1);
    begin
      int base;
      base = starts_seen;
      do_start(ROUTINE_CONTINUOUS);
      wait_starts("cont_reads", base + 3, 60);
    end
    @(posedge clk); #1 continuous_stop_i = 1'b1;
    @(posedge clk); #1 continuous_stop_i = 1'b0;
    wait_done("continuous", 60);
    @(negedge clk);
    check("cont_hold", command_o, 24'h0F0000);

    resp_lat = 2;
    push_start(24'h100300); push_done(1);
    do_start(ROUTINE_READBACK);
    wait_done("rb_after_cont", 50);

    // Reset while SGL_WAKEUP is in flight: abort with no done_o
    push_start(24'hFC0000); push_start(24'h000000);
    begin
      int base;
      base = starts_seen;
      do_start(ROUTINE_SINGLE);
      wait_starts("sgl_wakeup", base + 2, 30);
    end
    @(posedge clk); #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    check("abort_start", transaction_start_o, 0);
    check("abort_done", done_o, 0);
    check("abort_command", command_o, 24'h000000);
    repeat (6) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
